// File: rtl/mvm_pkg.sv
`default_nettype none
// ============================================================================
// Package     : mvm_pkg
// Description : Shared widths, frame constants and serializer state type for
//               the matrix-vector multiplier datapath.
// Revision    : 1.0
// ============================================================================
package mvm_pkg;

    localparam logic [7:0] FRAME_HDR = 8'hA5;

    // Output element width: full product plus the growth of a C-term sum.
    function automatic int calc_w_y(input int w_x, input int w_k, input int c);
        return w_x + w_k + $clog2(c);
    endfunction

    function automatic int calc_bpe(input int w_y);
        return (w_y + 7) / 8;
    endfunction

    function automatic int calc_npay(input int r, input int bpe);
        return r * bpe;
    endfunction

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HDR  = 2'd1,
        S_DATA = 2'd2,
        S_CSUM = 2'd3
    } ser_state_t;

endpackage : mvm_pkg
`default_nettype wire

// File: rtl/axis_y_byte_serializer.sv
`default_nettype none
// ============================================================================
// Module      : axis_y_byte_serializer
// Description : Turns one wide MVM result beat into a framed byte stream
//               (header, sign-extended little-endian payload, XOR checksum).
// Revision    : 1.0
// ============================================================================
module axis_y_byte_serializer
    import mvm_pkg::*;
#(
    parameter int         R   = 8,
    parameter int         C   = 8,
    parameter int         W_X = 8,
    parameter int         W_K = 8,
    parameter logic [7:0] HDR = FRAME_HDR
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          s_axis_y_tvalid,
    output logic                                          s_axis_y_tready,
    input  logic [R*calc_w_y(W_X, W_K, C)-1:0]            s_axis_y_tdata,
    output logic                                          m_axis_tvalid,
    input  logic                                          m_axis_tready,
    output logic [7:0]                                    m_axis_tdata,
    output logic                                          m_axis_tlast
);

    localparam int W_Y  = calc_w_y(W_X, W_K, C);
    localparam int BPE  = calc_bpe(W_Y);
    localparam int NPAY = calc_npay(R, BPE);
    localparam int SXW  = BPE * 8;
    localparam int CNTW = $clog2(NPAY);
    localparam int LSBW = CNTW + 3;

    ser_state_t          r_state;
    logic [R*SXW-1:0]    w_sx;
    logic [R*SXW-1:0]    r_buf;
    logic [CNTW-1:0]     r_cnt;
    logic [CNTW-1:0]     w_sel;
    logic [LSBW-1:0]     w_lsb;
    logic [7:0]          w_byte;
    logic [7:0]          r_csum;
    logic [7:0]          w_csum_next;
    logic [7:0]          r_tdata;
    logic                r_tvalid;
    logic                r_tlast;
    logic                r_s_tready;
    logic                w_s_hs;
    logic                w_m_hs;

    // Each element widened to a whole number of bytes so the payload is a
    // flat byte array and byte index == payload counter.
    for (genvar i = 0; i < R; i++) begin : g_elem
        if (SXW > W_Y) begin : g_ext
            assign w_sx[i*SXW +: SXW] = {{(SXW-W_Y){s_axis_y_tdata[i*W_Y+W_Y-1]}},
                                         s_axis_y_tdata[i*W_Y +: W_Y]};
        end else begin : g_noext
            assign w_sx[i*SXW +: SXW] = s_axis_y_tdata[i*W_Y +: W_Y];
        end
    end

    assign w_s_hs = s_axis_y_tvalid & r_s_tready;
    assign w_m_hs = r_tvalid & m_axis_tready;

    // Selects the byte to present after the current handshake.
    always_comb begin
        w_sel = '0;
        if (r_state == S_DATA && r_cnt != CNTW'(NPAY-1)) begin
            w_sel = r_cnt + CNTW'(1);
        end
    end

    assign w_lsb       = {w_sel, 3'b000};
    assign w_byte      = r_buf[w_lsb +: 8];
    assign w_csum_next = r_csum ^ r_tdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_buf      <= '0;
            r_cnt      <= '0;
            r_csum     <= '0;
            r_tdata    <= '0;
            r_tvalid   <= 1'b0;
            r_tlast    <= 1'b0;
            r_s_tready <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_s_hs) begin
                        r_buf      <= w_sx;
                        r_csum     <= '0;
                        r_s_tready <= 1'b0;
                        r_tvalid   <= 1'b1;
                        r_tdata    <= HDR;
                        r_tlast    <= 1'b0;
                        r_state    <= S_HDR;
                    end
                end
                S_HDR: begin
                    if (w_m_hs) begin
                        r_cnt   <= '0;
                        r_tdata <= w_byte;
                        r_state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_m_hs) begin
                        r_csum <= w_csum_next;
                        if (r_cnt == CNTW'(NPAY-1)) begin
                            r_tdata <= w_csum_next;
                            r_tlast <= 1'b1;
                            r_state <= S_CSUM;
                        end else begin
                            r_cnt   <= r_cnt + CNTW'(1);
                            r_tdata <= w_byte;
                        end
                    end
                end
                S_CSUM: begin
                    if (w_m_hs) begin
                        r_tvalid   <= 1'b0;
                        r_tlast    <= 1'b0;
                        r_s_tready <= 1'b1;
                        r_state    <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign s_axis_y_tready = r_s_tready;
    assign m_axis_tvalid   = r_tvalid;
    assign m_axis_tdata    = r_tdata;
    assign m_axis_tlast    = r_tlast;

endmodule : axis_y_byte_serializer
`default_nettype wire
